raw_capture: RTL and testbench

RAW_CAPTURE -- requirements
Module: raw_capture

---
 rtl/raw_capture_pkg.sv | 19 +
 rtl/raw_capture_edge.sv | 29 ++
 rtl/raw_capture.sv | 234 +++++++++++++++++++++++
 tb/tb_raw_capture.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/raw_capture_pkg.sv
// Shared types and defaults for the raw sensor capture front end and the debayer stage.
package raw_capture_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWaitSof = 2'd1,
    StActive  = 2'd2
  } cap_state_e;

  typedef logic [15:0] coord_t;

  localparam int unsigned HActiveDefault = 1920;
  localparam int unsigned VActiveDefault = 1080;

  function automatic coord_t coord_inc(input coord_t c);
    return c + coord_t'(1);
  endfunction

endpackage

// File: rtl/raw_capture_edge.sv
// Rising/falling edge detector for the registered FVAL/LVAL strobes.
module raw_capture_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic prev_q, prev_d;

  always_comb begin
    prev_d = sig_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  always_comb begin
    rise_o = sig_i & ~prev_q;
    fall_o = ~sig_i & prev_q;
  end

endmodule

// File: rtl/raw_capture.sv
// Raw sensor capture: arm/disarm FSM, pixel/line counters, cropping, 2-cycle latency.
// Optional line/frame size checker enabled by defining RAW_CAPTURE_ERR_EN.
module raw_capture
  import raw_capture_pkg::*;
#(
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned H_ACTIVE = HActiveDefault,
  parameter int unsigned V_ACTIVE = VActiveDefault
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iFVAL,
  input  logic              iLVAL,
  input  logic              iSTART,
  input  logic              iEND,
  output logic [DATA_W-1:0] oDATA,
  output logic              oDVAL,
  output logic [15:0]       oX_Cont,
  output logic [15:0]       oY_Cont,
  output logic [31:0]       oFrame_Cont,
  output logic              oSOF
`ifdef RAW_CAPTURE_ERR_EN
  ,
  output logic              oLine_Err
`endif
);

  localparam coord_t HLim = coord_t'(H_ACTIVE);
  localparam coord_t VLim = coord_t'(V_ACTIVE);

  // Input stage
  logic [DATA_W-1:0] data_s1_q, data_s1_d;
  logic              fval_s1_q, fval_s1_d;
  logic              lval_s1_q, lval_s1_d;

  logic fval_rise, fval_fall;
  logic lval_rise, lval_fall;

  // Control and counters
  cap_state_e  state_q, state_d;
  logic        disarm_q, disarm_d;
  coord_t      x_q, x_d;
  coord_t      y_q, y_d;
  logic [31:0] frame_q, frame_d;

  // Output stage
  logic [DATA_W-1:0] data_q, data_d;
  logic              dval_q, dval_d;
  coord_t            xo_q, xo_d;
  coord_t            yo_q, yo_d;
  logic              sof_q, sof_d;

  logic   capturing;
  logic   sof_entry;
  logic   accept;
  logic   line_done;
  logic   frame_done;
  coord_t cur_x;
  coord_t cur_y;

  always_comb begin
    data_s1_d = iDATA;
    fval_s1_d = iFVAL;
    lval_s1_d = iLVAL;
  end

  raw_capture_edge u_fval_edge (
    .clk_i  (iCLK),
    .rst_i  (iRST),
    .sig_i  (fval_s1_q),
    .rise_o (fval_rise),
    .fall_o (fval_fall)
  );

  raw_capture_edge u_lval_edge (
    .clk_i  (iCLK),
    .rst_i  (iRST),
    .sig_i  (lval_s1_q),
    .rise_o (lval_rise),
    .fall_o (lval_fall)
  );

  always_comb begin
    state_d    = state_q;
    disarm_d   = disarm_q;
    frame_d    = frame_q;
    capturing  = 1'b0;
    sof_entry  = 1'b0;
    frame_done = 1'b0;

    // iSTART wins over a simultaneous iEND
    if (iSTART) begin
      disarm_d = 1'b0;
    end else if (iEND) begin
      disarm_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        disarm_d = 1'b0;
        if (iSTART) begin
          state_d = StWaitSof;
        end
      end
      StWaitSof: begin
        if (iEND && !iSTART) begin
          state_d  = StIdle;
          disarm_d = 1'b0;
        end else if (fval_rise) begin
          state_d   = StActive;
          sof_entry = 1'b1;
          capturing = 1'b1;
        end
      end
      StActive: begin
        capturing = 1'b1;
        if (fval_fall) begin
          frame_done = 1'b1;
          if (disarm_d) begin
            state_d  = StIdle;
            disarm_d = 1'b0;
          end else begin
            state_d = StWaitSof;
          end
        end
      end
      default: begin
        state_d  = StIdle;
        disarm_d = 1'b0;
      end
    endcase

    if (frame_done) begin
      frame_d = frame_q + 32'd1;
    end
  end

  // Coordinates of the pixel sitting in the input stage this cycle
  always_comb begin
    cur_x = (sof_entry || (capturing && lval_rise)) ? '0 : x_q;
    cur_y = sof_entry ? '0 : y_q;

    accept    = capturing & fval_s1_q & lval_s1_q;
    line_done = capturing & lval_fall & (cur_x != '0);

    x_d = cur_x;
    y_d = cur_y;
    if (accept) begin
      x_d = coord_inc(cur_x);
    end else if (capturing && lval_fall) begin
      x_d = '0;
    end
    if (line_done) begin
      y_d = coord_inc(cur_y);
    end

    data_d = data_s1_q;
    dval_d = accept && (cur_x < HLim) && (cur_y < VLim);
    sof_d  = dval_d && (cur_x == '0) && (cur_y == '0);
    xo_d   = cur_x;
    yo_d   = cur_y;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      data_s1_q <= '0;
      fval_s1_q <= 1'b0;
      lval_s1_q <= 1'b0;
      state_q   <= StIdle;
      disarm_q  <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      frame_q   <= '0;
      data_q    <= '0;
      dval_q    <= 1'b0;
      xo_q      <= '0;
      yo_q      <= '0;
      sof_q     <= 1'b0;
    end else begin
      data_s1_q <= data_s1_d;
      fval_s1_q <= fval_s1_d;
      lval_s1_q <= lval_s1_d;
      state_q   <= state_d;
      disarm_q  <= disarm_d;
      x_q       <= x_d;
      y_q       <= y_d;
      frame_q   <= frame_d;
      data_q    <= data_d;
      dval_q    <= dval_d;
      xo_q      <= xo_d;
      yo_q      <= yo_d;
      sof_q     <= sof_d;
    end
  end

`ifdef RAW_CAPTURE_ERR_EN
  logic   err_q, err_d;
  coord_t lines_total;

  always_comb begin
    lines_total = line_done ? coord_inc(cur_y) : cur_y;
    err_d       = err_q;
    if (iSTART) begin
      err_d = 1'b0;
    end else begin
      if (line_done && (cur_x != HLim)) begin
        err_d = 1'b1;
      end
      if (frame_done && (lines_total != VLim)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign oLine_Err = err_q;
`endif

  assign oDATA       = data_q;
  assign oDVAL       = dval_q;
  assign oX_Cont     = xo_q;
  assign oY_Cont     = yo_q;
  assign oFrame_Cont = frame_q;
  assign oSOF        = sof_q;

endmodule

// File: tb/tb_raw_capture.sv
// Directed bench for raw_capture with an 8x4 active window (H_ACTIVE=8, V_ACTIVE=4).
module tb_raw_capture;

  localparam int DW = 12;

  logic          iCLK = 1'b0;
  logic          iRST = 1'b1;
  logic [DW-1:0] iDATA = '0;
  logic          iFVAL = 1'b0;
  logic          iLVAL = 1'b0;
  logic          iSTART = 1'b0;
  logic          iEND = 1'b0;
  logic [DW-1:0] oDATA;
  logic          oDVAL;
  logic [15:0]   oX_Cont;
  logic [15:0]   oY_Cont;
  logic [31:0]   oFrame_Cont;
  logic          oSOF;
`ifdef RAW_CAPTURE_ERR_EN
  logic          oLine_Err;
`endif

  raw_capture #(
    .DATA_W   (DW),
    .H_ACTIVE (8),
    .V_ACTIVE (4)
  ) dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iDATA       (iDATA),
    .iFVAL       (iFVAL),
    .iLVAL       (iLVAL),
    .iSTART      (iSTART),
    .iEND        (iEND),
    .oDATA       (oDATA),
    .oDVAL       (oDVAL),
    .oX_Cont     (oX_Cont),
    .oY_Cont     (oY_Cont),
    .oFrame_Cont (oFrame_Cont),
    .oSOF        (oSOF)
`ifdef RAW_CAPTURE_ERR_EN
    ,
    .oLine_Err   (oLine_Err)
`endif
  );

  always #5 iCLK = ~iCLK;

  int n_tests = 0;
  int n_fail  = 0;
  int stride  = 8;

  // Monitor totals; only the monitor writes them, tests compare deltas
  int dval_cnt = 0, sof_cnt = 0, sof_bad = 0, coord_bad = 0, lat_bad = 0;
  int data_sum = 0, last_data = -1;
  int rst_age = 0;
  logic [DW-1:0] h1 = '0, h2 = '0;

  always @(posedge iCLK) begin
    h2 = h1;
    h1 = iDATA;
    if (iRST) rst_age = 0;
    else if (rst_age < 100) rst_age++;
  end

  always @(negedge iCLK) begin
    if (oDVAL) begin
      dval_cnt++;
      data_sum += int'(oDATA);
      last_data = int'(oDATA);
      if (int'(oDATA) != int'(oX_Cont) + stride * int'(oY_Cont)) coord_bad++;
      if (oX_Cont >= 16'd8 || oY_Cont >= 16'd4) coord_bad++;
    end
    if (oSOF) begin
      sof_cnt++;
      if (!oDVAL || oDATA != '0) sof_bad++;
    end
    if (rst_age >= 2 && oDATA != h2) lat_bad++;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic pulse_start();
    iSTART = 1'b1;
    tick();
    iSTART = 1'b0;
  endtask

  task automatic pulse_end();
    iEND = 1'b1;
    tick();
    iEND = 1'b0;
  endtask

  // Pixel index start_at/end_at/rst_at pulses the matching control on that pixel (-1: none)
  task automatic send_frame(input int lines, input int pix, input int str,
                            input int start_at, input int end_at, input int rst_at);
    int idx;
    idx = 0;
    iFVAL = 1'b1;
    tick();
    tick();
    for (int y = 0; y < lines; y++) begin
      iLVAL = 1'b1;
      for (int x = 0; x < pix; x++) begin
        iDATA  = DW'(x + str * y);
        iSTART = (idx == start_at);
        iEND   = (idx == end_at);
        iRST   = (idx == rst_at);
        tick();
        if (iRST) begin
          iRST = 1'b0;
          check("rst_outputs_zero", longint'({oDATA, oDVAL, oSOF, oX_Cont, oY_Cont}), 0);
          check("rst_frame_cnt_zero", longint'(oFrame_Cont), 0);
        end
        iSTART = 1'b0;
        iEND   = 1'b0;
        idx++;
      end
      iLVAL = 1'b0;
      iDATA = '0;
      repeat (3) tick();
    end
    iFVAL = 1'b0;
    repeat (5) tick();
  endtask

  typedef struct {
    string name;
    int    lines;
    int    pix;
    int    str;
    int    exp_pulses;
    int    exp_sum;
    int    exp_last;
    bit    exp_err;
  } vec_t;

  vec_t vecs[4];

  int d0, s0, sb0, cb0, lb0, sum0;
  logic [31:0] f0;

  task automatic snap();
    d0 = dval_cnt; s0 = sof_cnt; sb0 = sof_bad; cb0 = coord_bad; lb0 = lat_bad;
    sum0 = data_sum; f0 = oFrame_Cont;
  endtask

  task automatic check_frame(input string name, input int pulses, input int frames);
    check({name, "_pulses"}, dval_cnt - d0, pulses);
    check({name, "_frames"}, longint'(oFrame_Cont - f0), frames);
    check({name, "_coord"}, coord_bad - cb0, 0);
    check({name, "_latency"}, lat_bad - lb0, 0);
    if (pulses > 0) begin
      check({name, "_sof"}, sof_cnt - s0, 1);
      check({name, "_sof_data"}, sof_bad - sb0, 0);
    end
  endtask

  initial begin
    vecs[0] = '{"full8x4",  4, 8,  8,  32, 496, 31, 1'b0};
    vecs[1] = '{"crop10x6", 6, 10, 16, 32, 880, 55, 1'b1};
    vecs[2] = '{"short6x3", 3, 6,  8,  18, 189, 21, 1'b1};
    vecs[3] = '{"again8x4", 4, 8,  8,  32, 496, 31, 1'b0};

    repeat (3) tick();
    check("reset_data", longint'(oDATA), 0);
    check("reset_dval", longint'(oDVAL), 0);
    check("reset_sof", longint'(oSOF), 0);
    check("reset_frame_cnt", longint'(oFrame_Cont), 0);
`ifdef RAW_CAPTURE_ERR_EN
    check("reset_line_err", longint'(oLine_Err), 0);
`endif
    iRST = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      stride = vecs[i].str;
      pulse_start();
      snap();
      send_frame(vecs[i].lines, vecs[i].pix, vecs[i].str, -1, -1, -1);
      check_frame(vecs[i].name, vecs[i].exp_pulses, 1);
      check({vecs[i].name, "_sum"}, data_sum - sum0, vecs[i].exp_sum);
      check({vecs[i].name, "_last"}, last_data, vecs[i].exp_last);
`ifdef RAW_CAPTURE_ERR_EN
      check({vecs[i].name, "_line_err"}, longint'(oLine_Err), longint'(vecs[i].exp_err));
`endif
    end
    stride = 8;

    // iEND while waiting for SOF disarms at once
    pulse_end();
    snap();
    send_frame(4, 8, 8, -1, -1, -1);
    check_frame("end_in_wait", 0, 0);

    // Arming mid-frame skips that frame
    snap();
    send_frame(4, 8, 8, 5, -1, -1);
    check_frame("armed_mid_frame", 0, 0);
    snap();
    send_frame(4, 8, 8, -1, -1, -1);
    check_frame("frame_after_mid_arm", 32, 1);

    // iEND mid-frame takes effect at frame end
    snap();
    send_frame(4, 8, 8, -1, 10, -1);
    check_frame("end_mid_frame", 32, 1);
    snap();
    send_frame(4, 8, 8, -1, -1, -1);
    check_frame("after_disarm", 0, 0);

    iSTART = 1'b1;
    iEND   = 1'b1;
    tick();
    iSTART = 1'b0;
    iEND   = 1'b0;
    snap();
    send_frame(4, 8, 8, -1, -1, -1);
    check_frame("start_end_same", 32, 1);

    // Reset at pixel 13 drops the frame and requires re-arming
    pulse_start();
    send_frame(4, 8, 8, -1, -1, 13);
    check("rst_frame_dropped", longint'(oFrame_Cont), 0);
    snap();
    pulse_start();
    send_frame(4, 8, 8, -1, -1, -1);
    check_frame("after_reset", 32, 1);
    check("after_reset_total", longint'(oFrame_Cont), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
